// File: rtl/fp_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_add_pkg
// Description : Shared FP-adder constants and the shifter level-split helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_add_pkg;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Number of log2 shift levels placed in stage s; earlier stages take the remainder.
    function automatic int lvls_per_stage(input int w, input int stages, input int s);
        int l;
        l = $clog2(w);
        return (l / stages) + ((s < (l % stages)) ? 1 : 0);
    endfunction

    function automatic int first_lvl(input int w, input int stages, input int s);
        int acc;
        acc = 0;
        for (int i = 0; i < s; i++) acc += lvls_per_stage(w, stages, i);
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_level.sv
`default_nettype none
// ============================================================================
// Module      : shift_level
// Description : One conditional 2^K logical shift with sticky merge on right.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_level
    import fp_add_pkg::*;
#(
    parameter int W = 32,
    parameter int K = 0
) (
    input  logic [W-1:0] i_data,
    input  logic         i_sticky,
    input  logic         i_en,
    input  logic         i_dir,
    output logic [W-1:0] o_data,
    output logic         o_sticky
);

    localparam int c_n = 1 << K;

    always_comb begin
        o_data   = i_data;
        o_sticky = i_sticky;
        if (i_en) begin
            if (i_dir == DIR_LEFT) begin
                o_data = i_data << c_n;
            end else begin
                o_data   = i_data >> c_n;
                o_sticky = i_sticky | (|i_data[c_n-1:0]);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/align_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module      : align_shift_pipe
// Description : Pipelined logical barrel shifter with sticky collection and
//               valid/ready handshake; shift levels spread over STAGES registers.
// Revision    : 1.0 - initial release
// ============================================================================
module align_shift_pipe
    import fp_add_pkg::*;
#(
    parameter int  W      = 32,
    parameter int  SW     = $clog2(W) + 1,
    parameter int  STAGES = 2,
    parameter real T      = 0.000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [SW-1:0] in_amt,
    input  logic          in_dir,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_sticky
);

    localparam int c_lvls = $clog2(W);

    logic w_adv;
    logic w_sat;

    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;
    assign w_sat    = (in_amt >= SW'(W));

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int c_first = first_lvl(W, STAGES, s);
        localparam int c_n     = lvls_per_stage(W, STAGES, s);
        localparam int c_rem   = c_lvls - c_first;

        logic [W-1:0]     w_d_in;
        logic             w_s_in;
        logic [c_rem-1:0] w_amt;
        logic             w_dir;
        logic             w_sat_in;
        logic             w_sat_sticky;
        logic             w_v_in;
        logic [W-1:0]     r_d;
        logic             r_s;
        logic             r_v;

        if (s == 0) begin : g_head
            assign w_d_in       = in_data;
            assign w_s_in       = 1'b0;
            assign w_amt        = in_amt[c_rem-1:0];
            assign w_dir        = in_dir;
            assign w_sat_in     = w_sat;
            assign w_sat_sticky = (in_dir == DIR_RIGHT) & (|in_data);
            assign w_v_in       = in_valid;
        end else begin : g_body
            assign w_d_in       = g_stage[s-1].r_d;
            assign w_s_in       = g_stage[s-1].r_s;
            assign w_amt        = g_stage[s-1].g_carry.r_amt;
            assign w_dir        = g_stage[s-1].g_carry.r_dir;
            assign w_sat_in     = g_stage[s-1].g_carry.r_sat;
            assign w_sat_sticky = g_stage[s-1].r_s;
            assign w_v_in       = g_stage[s-1].r_v;
        end

        for (genvar j = 0; j < c_n; j++) begin : g_lvl
            logic [W-1:0] w_din;
            logic [W-1:0] w_dout;
            logic         w_sin;
            logic         w_sout;

            if (j == 0) begin : g_first
                assign w_din = w_d_in;
                assign w_sin = w_s_in;
            end else begin : g_next
                assign w_din = g_lvl[j-1].w_dout;
                assign w_sin = g_lvl[j-1].w_sout;
            end

            shift_level #(
                .W (W),
                .K (c_first + j)
            ) u_lvl (
                .i_data   (w_din),
                .i_sticky (w_sin),
                .i_en     (w_amt[j]),
                .i_dir    (w_dir),
                .o_data   (w_dout),
                .o_sticky (w_sout)
            );
        end

        // Saturated beats carry zero data; the sticky was settled in stage 1.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v <= 1'b0;
                r_d <= '0;
                r_s <= 1'b0;
            end else if (w_adv) begin
                r_v <= w_v_in;
                r_d <= w_sat_in ? '0 : g_lvl[c_n-1].w_dout;
                r_s <= w_sat_in ? w_sat_sticky : g_lvl[c_n-1].w_sout;
            end
        end

        // Only the amount bits still needed downstream are carried forward.
        if (s < STAGES - 1) begin : g_carry
            logic [c_rem-c_n-1:0] r_amt;
            logic                 r_dir;
            logic                 r_sat;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_amt <= '0;
                    r_dir <= 1'b0;
                    r_sat <= 1'b0;
                end else if (w_adv) begin
                    r_amt <= w_amt[c_rem-1:c_n];
                    r_dir <= w_dir;
                    r_sat <= w_sat_in;
                end
            end
        end
    end

    assign out_valid  = g_stage[STAGES-1].r_v;
    assign out_data   = g_stage[STAGES-1].r_d;
    assign out_sticky = g_stage[STAGES-1].r_s;

endmodule
`default_nettype wire

// File: tb/tb_align_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_align_shift_pipe
// Description : Directed self-checking bench for align_shift_pipe (3 configs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_align_shift_pipe;
    import fp_add_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // W=32, STAGES=2
    logic        a_in_valid, a_in_ready, a_in_dir, a_out_valid, a_out_ready, a_out_sticky;
    logic [31:0] a_in_data, a_out_data;
    logic [5:0]  a_in_amt;
    // W=24, STAGES=1
    logic        b_in_valid, b_in_ready, b_in_dir, b_out_valid, b_out_ready, b_out_sticky;
    logic [23:0] b_in_data, b_out_data;
    logic [5:0]  b_in_amt;
    // W=64, STAGES=6
    logic        c_in_valid, c_in_ready, c_in_dir, c_out_valid, c_out_ready, c_out_sticky;
    logic [63:0] c_in_data, c_out_data;
    logic [6:0]  c_in_amt;

    align_shift_pipe #(.W(32), .STAGES(2)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_amt(a_in_amt), .in_dir(a_in_dir),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_sticky(a_out_sticky)
    );

    align_shift_pipe #(.W(24), .STAGES(1)) u_dut24 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_amt(b_in_amt), .in_dir(b_in_dir),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_sticky(b_out_sticky)
    );

    align_shift_pipe #(.W(64), .STAGES(6)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_amt(c_in_amt), .in_dir(c_in_dir),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .out_sticky(c_out_sticky)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: whole-amount shift, no level structure.
    function automatic void model(input logic [63:0] d_in, input int amt, input logic dir,
                                  input int w, output logic [63:0] r, output logic s);
        logic [63:0] mask;
        logic [63:0] d;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        d    = d_in & mask;
        if (amt >= w) begin
            r = '0;
            s = (dir == DIR_RIGHT) ? (|d) : 1'b0;
        end else if (dir == DIR_LEFT) begin
            r = (d << amt) & mask;
            s = 1'b0;
        end else begin
            r = d >> amt;
            s = |(d & ((64'd1 << amt) - 64'd1));
        end
    endfunction

    task automatic beat32(input string tag, input logic [31:0] d, input logic [5:0] amt,
                          input logic dir, input logic [31:0] exp_d, input logic exp_s);
        @(negedge clk);
        a_in_valid = 1'b1; a_in_data = d; a_in_amt = amt; a_in_dir = dir;
        @(negedge clk);
        a_in_valid = 1'b0;
        check({tag, "_early"}, a_out_valid, 0);
        @(negedge clk);
        check({tag, "_valid"}, a_out_valid, 1);
        check({tag, "_data"}, a_out_data, exp_d);
        check({tag, "_sticky"}, a_out_sticky, exp_s);
    endtask

    task automatic beat24(input string tag, input logic [23:0] d, input logic [5:0] amt,
                          input logic dir, input logic [63:0] exp_d, input logic exp_s);
        @(negedge clk);
        b_in_valid = 1'b1; b_in_data = d; b_in_amt = amt; b_in_dir = dir;
        @(negedge clk);
        b_in_valid = 1'b0;
        check({tag, "_valid"}, b_out_valid, 1);
        check({tag, "_data"}, b_out_data, exp_d);
        check({tag, "_sticky"}, b_out_sticky, exp_s);
    endtask

    task automatic beat64(input string tag, input logic [63:0] d, input logic [6:0] amt,
                          input logic dir, input logic [63:0] exp_d, input logic exp_s);
        @(negedge clk);
        c_in_valid = 1'b1; c_in_data = d; c_in_amt = amt; c_in_dir = dir;
        @(negedge clk);
        c_in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check({tag, "_early"}, c_out_valid, 0);
        @(negedge clk);
        check({tag, "_valid"}, c_out_valid, 1);
        check({tag, "_data"}, c_out_data, exp_d);
        check({tag, "_sticky"}, c_out_sticky, exp_s);
    endtask

    initial begin
        logic [31:0] sd [4];
        logic [31:0] se [4];
        logic        ss [4];
        logic [63:0] rd;
        logic [63:0] exp_r;
        logic        exp_s;
        logic [5:0]  ra6;
        logic [6:0]  ra7;
        logic        rdir;

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_in_amt = '0; a_in_dir = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_amt = '0; b_in_dir = 1'b0; b_out_ready = 1'b1;
        c_in_valid = 1'b0; c_in_data = '0; c_in_amt = '0; c_in_dir = 1'b0; c_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", a_out_valid, 0);
        check("rst_data", a_out_data, 0);
        check("rst_sticky", a_out_sticky, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", a_in_ready, 1);

        beat32("r4",     32'h000000FF, 6'd4,  DIR_RIGHT, 32'h0000000F, 1'b1);
        beat32("l8",     32'h000000FF, 6'd8,  DIR_LEFT,  32'h0000FF00, 1'b0);
        beat32("a0",     32'h000000FF, 6'd0,  DIR_RIGHT, 32'h000000FF, 1'b0);
        beat32("sat_r",  32'h80000001, 6'd40, DIR_RIGHT, 32'h00000000, 1'b1);
        beat32("sat_l",  32'h80000001, 6'd40, DIR_LEFT,  32'h00000000, 1'b0);
        beat32("r31",    32'h80000001, 6'd31, DIR_RIGHT, 32'h00000001, 1'b1);
        beat32("sat_32", 32'hFFFFFFFF, 6'd32, DIR_RIGHT, 32'h00000000, 1'b1);

        // Streaming: four back-to-back beats, outputs in order from cycle 2.
        sd[0] = 32'h11111111; se[0] = 32'h11111111; ss[0] = 1'b0;
        sd[1] = 32'h22222222; se[1] = 32'h11111111; ss[1] = 1'b0;
        sd[2] = 32'h33333333; se[2] = 32'h0CCCCCCC; ss[2] = 1'b1;
        sd[3] = 32'h44444444; se[3] = 32'h08888888; ss[3] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("stream_ready%0d", i), a_in_ready, 1);
            if (i >= 2) begin
                check($sformatf("stream_valid%0d", i - 2), a_out_valid, 1);
                check($sformatf("stream_data%0d", i - 2), a_out_data, se[i-2]);
                check($sformatf("stream_sticky%0d", i - 2), a_out_sticky, ss[i-2]);
            end
            if (i < 4) begin
                a_in_valid = 1'b1; a_in_data = sd[i]; a_in_amt = 6'(i); a_in_dir = DIR_RIGHT;
            end else begin
                a_in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("stream_drain", a_out_valid, 0);

        // Backpressure: A stalls at the output for three cycles, B and C queue behind.
        @(negedge clk);
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 32'hA5A5A5A5; a_in_amt = 6'd1; a_in_dir = DIR_LEFT;
        @(negedge clk);
        check("bp_ready_pre", a_in_ready, 1);
        a_in_data = 32'h0000FFFF; a_in_amt = 6'd16; a_in_dir = DIR_RIGHT;
        @(negedge clk);
        check("bp_ready0", a_in_ready, 0);
        check("bp_data0", a_out_data, 32'h4B4B4B4A);
        a_in_data = 32'h12345678; a_in_amt = 6'd4; a_in_dir = DIR_RIGHT;
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp_valid%0d", i), a_out_valid, 1);
            check($sformatf("bp_ready%0d", i), a_in_ready, 0);
            check($sformatf("bp_data%0d", i), a_out_data, 32'h4B4B4B4A);
            check($sformatf("bp_sticky%0d", i), a_out_sticky, 0);
        end
        a_out_ready = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        check("bp_b_valid", a_out_valid, 1);
        check("bp_b_data", a_out_data, 32'h00000000);
        check("bp_b_sticky", a_out_sticky, 1);
        @(negedge clk);
        check("bp_c_valid", a_out_valid, 1);
        check("bp_c_data", a_out_data, 32'h01234567);
        check("bp_c_sticky", a_out_sticky, 1);
        @(negedge clk);
        check("bp_drain", a_out_valid, 0);

        // Asynchronous reset with two beats in flight.
        @(negedge clk);
        a_in_valid = 1'b1; a_in_data = 32'h000000FF; a_in_amt = 6'd0; a_in_dir = DIR_RIGHT;
        @(negedge clk);
        a_in_data = 32'h0F0F0000; a_in_amt = 6'd4; a_in_dir = DIR_LEFT;
        @(negedge clk);
        a_in_valid = 1'b0;
        check("mid_pre_valid", a_out_valid, 1);
        check("mid_pre_data", a_out_data, 32'h000000FF);
        #2 rst_n = 1'b0;
        #1;
        check("mid_async_valid", a_out_valid, 0);
        check("mid_async_data", a_out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("mid_stale%0d", i), a_out_valid, 0);
        end

        // W=24, STAGES=1: non-power-of-2 width.
        beat24("w24_sat",  24'h800001, 6'd24, DIR_RIGHT, 64'h0, 1'b1);
        beat24("w24_r23",  24'h800001, 6'd23, DIR_RIGHT, 64'h1, 1'b1);
        beat24("w24_l5",   24'h800001, 6'd5,  DIR_LEFT,  64'h20, 1'b0);
        for (int i = 0; i < 6; i++) begin
            rd   = {$urandom(), $urandom()};
            ra6  = 6'($urandom_range(0, 30));
            rdir = 1'($urandom_range(0, 1));
            model(rd, int'(ra6), rdir, 24, exp_r, exp_s);
            beat24($sformatf("w24_rnd%0d", i), rd[23:0], ra6, rdir, exp_r, exp_s);
        end

        // W=64, STAGES=6: one level per stage.
        beat64("w64_r63", 64'h8000000000000001, 7'd63, DIR_RIGHT, 64'h1, 1'b1);
        beat64("w64_sat", 64'h8000000000000001, 7'd64, DIR_LEFT,  64'h0, 1'b0);
        beat64("w64_r32", 64'h00000000FFFFFFFF, 7'd32, DIR_RIGHT, 64'h0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            rd   = {$urandom(), $urandom()};
            ra7  = 7'($urandom_range(0, 70));
            rdir = 1'($urandom_range(0, 1));
            model(rd, int'(ra7), rdir, 64, exp_r, exp_s);
            beat64($sformatf("w64_rnd%0d", i), rd, ra7, rdir, exp_r, exp_s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
